ext_int_multi_gen: RTL and testbench

EXT_INT_MULTI_GEN -- requirements
Module: ext_int_multi_gen

---
 rtl/ext_int_multi_gen_pkg.sv | 9 +
 rtl/ext_int_chan.sv | 36 +++
 rtl/ext_int_multi_gen.sv | 39 +++
 tb/tb_ext_int_multi_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ext_int_multi_gen_pkg.sv
// ext_int_multi_gen_pkg: shared limits, default period and priority helper
package ext_int_multi_gen_pkg;
  localparam int MAX_CH = 16;
  localparam int DEF_PERIOD = 200;
  function automatic logic [3:0] first_set(input logic [MAX_CH-1:0] v);
    first_set = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) first_set = v[i] ? 4'(i) : first_set;
  endfunction
endpackage

// File: rtl/ext_int_chan.sv
// ext_int_chan: one periodic interrupt source (period, counter, pending, miss flag; miss flag only with EXT_INT_MISS_DETECT_EN)
module ext_int_chan import ext_int_multi_gen_pkg::*; #(
  parameter logic [31:0] DEFAULT_PERIOD = DEF_PERIOD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] period_in,
  input  logic        ack,
  output logic        pending,
  output logic        missed
);
  logic [31:0] period, cnt;
  logic expire;
  // a write restarts the count, so it also suppresses an expiry on that edge
  assign expire = !we && period != '0 && cnt == period - 32'd1;
  // period register, free-running counter and pending latch; expiry beats a same-edge ack
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      period  <= DEFAULT_PERIOD;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      period  <= we ? period_in : period;
      cnt     <= (we || expire || period == '0) ? '0 : cnt + 32'd1;
      pending <= expire | (pending & ~ack);
    end
`ifdef EXT_INT_MISS_DETECT_EN
  // sticky overrun flag: expiry onto an unacknowledged pending bit; cleared by ack
  always_ff @(posedge clk or posedge reset)
    if (reset) missed <= 1'b0;
    else missed <= (expire & pending & ~ack) | (missed & ~ack);
`else
  assign missed = 1'b0;
`endif
endmodule

// File: rtl/ext_int_multi_gen.sv
// ext_int_multi_gen: NUM_CH periodic interrupt generators with fixed-priority reporting (miss detection via EXT_INT_MISS_DETECT_EN)
module ext_int_multi_gen import ext_int_multi_gen_pkg::*; #(
  parameter int          NUM_CH         = 4,
  parameter logic [31:0] DEFAULT_PERIOD = DEF_PERIOD,
  parameter logic [NUM_CH-1:0] INIT_EN  = {NUM_CH{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic [31:0]       cfg_period,
  input  logic [NUM_CH-1:0] cfg_en,
  input  logic              ext_int_ack,
  output logic              external_int,
  output logic [3:0]        int_id,
  output logic [NUM_CH-1:0] int_missed
);
  logic [NUM_CH-1:0] pending, active;
  logic unused_init_en;
  // INIT_EN only advises the cfg_en driver; it has no effect inside this block
  assign unused_init_en = ^INIT_EN;
  assign active = pending & cfg_en;
  assign external_int = |active;
  assign int_id = first_set(MAX_CH'(active));
  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      ext_int_chan #(.DEFAULT_PERIOD(DEFAULT_PERIOD)) u_chan (
        .clk       (clk),
        .reset     (reset),
        .we        (cfg_we && cfg_ch == 4'(i)),
        .period_in (cfg_period),
        .ack       (ext_int_ack && external_int && int_id == 4'(i)),
        .pending   (pending[i]),
        .missed    (int_missed[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_ext_int_multi_gen.sv
// tb_ext_int_multi_gen: directed scenarios plus random traffic against an expiry-time model
module tb_ext_int_multi_gen;
  localparam int NUM_CH = 4;
`ifdef EXT_INT_MISS_DETECT_EN
  localparam bit MISS = 1'b1;
`else
  localparam bit MISS = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, cfg_we, ext_int_ack, external_int;
  logic [3:0] cfg_ch, int_id;
  logic [31:0] cfg_period;
  logic [NUM_CH-1:0] cfg_en, int_missed;
  int ncmp = 0, nfail = 0;
  longint ecount = 0;
  longint t0[NUM_CH], per[NUM_CH];
  bit m_pend[NUM_CH], m_miss[NUM_CH];

  ext_int_multi_gen #(.NUM_CH(NUM_CH)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
    .cfg_en(cfg_en), .ext_int_ack(ext_int_ack), .external_int(external_int),
    .int_id(int_id), .int_missed(int_missed)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  function automatic bit m_ext();
    for (int c = 0; c < NUM_CH; c++) if (m_pend[c] && cfg_en[c]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_id();
    for (int c = 0; c < NUM_CH; c++) if (m_pend[c] && cfg_en[c]) return c;
    return 0;
  endfunction

  // a channel loaded (or reset) at edge t0 with period p expires at edges t0+p, t0+2p, ...
  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      m_pend[c] = 0; m_miss[c] = 0; per[c] = 200; t0[c] = ecount;
    end
  endtask

  task automatic model_edge();
    bit ext, we, e, a;
    int id;
    if (reset) begin model_clear(); return; end
    ext = m_ext(); id = m_id();
    for (int c = 0; c < NUM_CH; c++) begin
      we = cfg_we && cfg_ch == 4'(c);
      e = !we && per[c] != 0 && ecount > t0[c] && (ecount - t0[c]) % per[c] == 0;
      a = ext_int_ack && ext && id == c;
      if (e && m_pend[c] && !a) m_miss[c] = 1; else if (a) m_miss[c] = 0;
      m_pend[c] = e ? 1'b1 : (a ? 1'b0 : m_pend[c]);
      if (we) begin per[c] = longint'(cfg_period); t0[c] = ecount; end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [NUM_CH-1:0] em;
    for (int c = 0; c < NUM_CH; c++) em[c] = MISS & m_miss[c];
    chk("external_int", 32'(external_int), 32'(m_ext()));
    chk("int_id", 32'(int_id), 32'(m_id()));
    chk("int_missed", 32'(int_missed), 32'(em));
  endtask

  task automatic tick();
    @(posedge clk);
    ecount++;
    model_edge();
    #1;
    check_model();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input int ch, input int p);
    cfg_we = 1'b1; cfg_ch = 4'(ch); cfg_period = 32'(p);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic ack1();
    ext_int_ack = 1'b1;
    tick();
    ext_int_ack = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && m_ext(); i++) ack1();
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_en = '1; ext_int_ack = 1'b0;
    model_clear();
    #1;
    chk("reset_ext", 32'(external_int), 32'd0);
    chk("reset_id", 32'(int_id), 32'd0);
    chk("reset_missed", 32'(int_missed), 32'd0);
    run(2);
    reset = 1'b0;
    // default period: first expiry exactly 200 edges after reset release
    run(199);
    chk("p200_before", 32'(external_int), 32'd0);
    tick();
    chk("p200_ext", 32'(external_int), 32'd1);
    chk("p200_id", 32'(int_id), 32'd0);
    ack1();
    chk("p200_ack_next_id", 32'(int_id), 32'd1);
    drain();
    chk("p200_drained", 32'(external_int), 32'd0);
    // ch1 and ch3 aligned on period 5, lower index reported first
    wr(0, 0); wr(2, 0); drain();
    wr(1, 5); run(4); wr(3, 5); ack1(); run(3); tick();
    chk("dual_ext", 32'(external_int), 32'd1);
    chk("dual_id1", 32'(int_id), 32'd1);
    ack1();
    chk("dual_id3", 32'(int_id), 32'd3);
    ack1();
    chk("dual_clear", 32'(external_int), 32'd0);
    wr(1, 0); wr(3, 0);
    // ch2 period 3 left unacknowledged overruns on second expiry
    wr(2, 3); run(6);
    chk("miss_set", 32'(int_missed[2]), 32'(MISS));
    chk("miss_id", 32'(int_id), 32'd2);
    ack1();
    chk("miss_ack", 32'(int_missed[2]), 32'd0);
    wr(2, 0); drain();
    // ack landing on the expiry edge keeps pending, no miss
    wr(0, 4); run(7);
    ext_int_ack = 1'b1; tick(); ext_int_ack = 1'b0;
    chk("coinc_ext", 32'(external_int), 32'd1);
    chk("coinc_id", 32'(int_id), 32'd0);
    chk("coinc_miss", 32'(int_missed[0]), 32'd0);
    ack1();
    chk("coinc_clear", 32'(external_int), 32'd0);
    wr(0, 0);
    // enable mask gates reporting combinationally
    wr(0, 1); tick(); wr(0, 0);
    cfg_en = 4'b1110; #1;
    chk("mask_off", 32'(external_int), 32'd0);
    check_model();
    cfg_en = 4'b1111; #1;
    chk("mask_on_ext", 32'(external_int), 32'd1);
    chk("mask_on_id", 32'(int_id), 32'd0);
    ack1();
    // period 0 never fires
    run(1000);
    chk("period0", 32'(external_int), 32'd0);
    // asynchronous reset mid-count discards pending and counters
    wr(1, 5); run(7);
    chk("pre_rst_id", 32'(int_id), 32'd1);
    #3; reset = 1'b1; model_clear(); #1;
    chk("async_rst_ext", 32'(external_int), 32'd0);
    chk("async_rst_id", 32'(int_id), 32'd0);
    tick();
    reset = 1'b0;
    run(199);
    chk("post_rst_quiet", 32'(external_int), 32'd0);
    tick();
    chk("post_rst_fire", 32'(external_int), 32'd1);
    drain();
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      cfg_we = ($urandom % 6) == 0;
      cfg_ch = 4'($urandom % 6);
      cfg_period = 32'($urandom % 10);
      ext_int_ack = ($urandom % 3) == 0;
      if ($urandom % 10 == 0) cfg_en = NUM_CH'($urandom);
      if ($urandom % 700 == 0) begin reset = 1'b1; model_clear(); end
      else reset = 1'b0;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
